// File: rtl/rp_ctrl_pkg.sv
// Shared types and defaults for the partial-reconfiguration decouple controller.
package rp_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    DRAIN     = 3'd1,
    DECOUPLED = 3'd2,
    RP_RST    = 3'd3,
    RELEASE   = 3'd4
  } rp_state_t;

  localparam int unsigned          LED_W_DEF       = 4;
  localparam logic [LED_W_DEF-1:0] SAFE_VAL_DEF    = 4'b0000;
  localparam int unsigned          DRAIN_CYC_DEF   = 16;
  localparam int unsigned          RST_CYC_DEF     = 8;
  localparam int unsigned          TIMEOUT_CYC_DEF = 1048576;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Wide enough to hold the largest cycle limit any phase compares against.
  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned w;
    w = $clog2(max3(a, b, c));
    return w + 1;
  endfunction

  localparam int unsigned TMR_W_DEF = tmr_width(DRAIN_CYC_DEF, RST_CYC_DEF, TIMEOUT_CYC_DEF);

endpackage

// File: rtl/rp_cycle_timer.sv
// Phase timer: up-counter cleared on state entry, flags when it reaches a terminal value.
module rp_cycle_timer
  import rp_ctrl_pkg::*;
#(
  parameter int unsigned TMR_W = TMR_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [TMR_W-1:0] i_term,
  output logic             o_hit
);

  logic [TMR_W-1:0] r_cnt;

  // Count enabled cycles since the last clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/rp_decouple_ctrl.sv
// Static-region controller sequencing partial reconfiguration of the shift and
// count RPs: owns the shift RP address counter, registers the RP LED buses and
// runs the freeze/decouple/load/reset/resume handshake with PS software.
// Optional: define RP_DECOUPLE_TIMEOUT_EN to add the pr_done watchdog and err.
module rp_decouple_ctrl
  import rp_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W       = 35,
  parameter int unsigned      ADDR_W      = 12,
  parameter int unsigned      LED_W       = LED_W_DEF,
  parameter int unsigned      DRAIN_CYC   = DRAIN_CYC_DEF,
  parameter int unsigned      RST_CYC     = RST_CYC_DEF,
  parameter logic [LED_W-1:0] SAFE_VAL    = SAFE_VAL_DEF,
  parameter int unsigned      TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              pl_clk,
  input  logic              pl_resetn,
  input  logic              rp_req,
  input  logic              pr_done,
  input  logic [LED_W-1:0]  shift_in,
  input  logic [LED_W-1:0]  count_in,
  output logic              rp_ack,
  output logic              rp_resetn,
  output logic [ADDR_W-1:0] addr_out,
  output logic [LED_W-1:0]  shift_out,
  output logic [LED_W-1:0]  count_out,
  output logic              busy
`ifdef RP_DECOUPLE_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned      TMR_W      = tmr_width(DRAIN_CYC, RST_CYC, TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] DRAIN_TERM = TMR_W'(DRAIN_CYC - 1);
  localparam logic [TMR_W-1:0] RST_TERM   = TMR_W'(RST_CYC - 1);
`ifdef RP_DECOUPLE_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMO_TERM   = TMR_W'(TIMEOUT_CYC - 1);
`endif

  rp_state_t        r_state;
  rp_state_t        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [LED_W-1:0] r_shift;
  logic [LED_W-1:0] r_count;
  logic             r_ack;
  logic             r_rp_resetn;
  logic             r_busy;
  logic             w_tmr_hit;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic [TMR_W-1:0] w_tmr_term;
  logic             w_timeout;
  logic             w_safe;

`ifdef RP_DECOUPLE_TIMEOUT_EN
  logic r_err;
  assign w_timeout = (r_state == DECOUPLED) && w_tmr_hit && !pr_done;
  assign err       = r_err;
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode; abort is only possible before the ack is given.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      RUN:       if (rp_req) w_next_state = DRAIN;
      DRAIN: begin
        if (!rp_req)        w_next_state = RUN;
        else if (w_tmr_hit) w_next_state = DECOUPLED;
      end
      DECOUPLED: if (pr_done || w_timeout) w_next_state = RP_RST;
      RP_RST:    if (w_tmr_hit) w_next_state = RELEASE;
      RELEASE:   if (!rp_req) w_next_state = RUN;
      default:   w_next_state = RUN;
    endcase
  end

  // Select which limit the shared timer compares against in the current phase.
  always_comb begin
    w_tmr_term = '0;
    w_tmr_en   = 1'b0;
    unique case (r_state)
      DRAIN: begin
        w_tmr_term = DRAIN_TERM;
        w_tmr_en   = 1'b1;
      end
      RP_RST: begin
        w_tmr_term = RST_TERM;
        w_tmr_en   = 1'b1;
      end
`ifdef RP_DECOUPLE_TIMEOUT_EN
      DECOUPLED: begin
        w_tmr_term = TMO_TERM;
        w_tmr_en   = 1'b1;
      end
`endif
      default: begin
        w_tmr_term = '0;
        w_tmr_en   = 1'b0;
      end
    endcase
  end

  // Timer restarts from zero on the edge that enters any new state.
  assign w_tmr_clr = (w_next_state != r_state);
  assign w_safe    = (w_next_state == DECOUPLED) || (w_next_state == RP_RST) ||
                     (w_next_state == RELEASE);

  rp_cycle_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .i_clk   (pl_clk),
    .i_rst_n (pl_resetn),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_term  (w_tmr_term),
    .o_hit   (w_tmr_hit)
  );

  // State register with handshake outputs decoded from the next state so they
  // change on the same edge as the state they describe.
  always_ff @(posedge pl_clk) begin
    if (!pl_resetn) begin
      r_state     <= RUN;
      r_ack       <= 1'b0;
      r_rp_resetn <= 1'b0;
      r_busy      <= 1'b0;
`ifdef RP_DECOUPLE_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_next_state;
      r_ack       <= (w_next_state == DECOUPLED) || (w_next_state == RP_RST);
      r_rp_resetn <= (w_next_state != RP_RST);
      r_busy      <= (w_next_state != RUN);
`ifdef RP_DECOUPLE_TIMEOUT_EN
      if (w_timeout) r_err <= 1'b1;
`endif
    end
  end

  // Free-running address counter, frozen outside RUN and never cleared by a handshake.
  always_ff @(posedge pl_clk) begin
    if (!pl_resetn) begin
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // LED pass-through: follow the RPs in RUN, hold through DRAIN, safe value once decoupled.
  always_ff @(posedge pl_clk) begin
    if (!pl_resetn) begin
      r_shift <= SAFE_VAL;
      r_count <= SAFE_VAL;
    end else if (w_safe) begin
      r_shift <= SAFE_VAL;
      r_count <= SAFE_VAL;
    end else if (r_state == RUN) begin
      r_shift <= shift_in;
      r_count <= count_in;
    end
  end

  assign rp_ack    = r_ack;
  assign rp_resetn = r_rp_resetn;
  assign busy      = r_busy;
  assign shift_out = r_shift;
  assign count_out = r_count;
  assign addr_out  = r_cnt[CNT_W-1 -: ADDR_W];

endmodule
